memory_stage_lsu: RTL and testbench

Second-generation memory stage of the 5-stage RISC-V pipeline, sitting between the execute/ME pipeline register and writeback.
- Adds sub-word loads/stores (byte/half/word, plus doubleword when DATA_W=64) with byte enables and sign/zero extension.
- Adds a variable-latency req/gnt/rvalid data-memory interface with upstream stall.
- Adds misalignment detection.
- Keeps branch resolution (pc_src_o) and the registered ME/WB boundary.

---
 rtl/memory_stage_lsu.sv | 158 +++++++++++++++
 tb/tb_memory_stage_lsu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_lsu.sv
// Memory stage: sub-word load/store with byte enables, req/gnt/rvalid data port, branch resolve, registered ME/WB boundary.
// Latency: non-memory ops one cycle; stores complete on gnt, loads on rvalid; stall_o holds upstream until then.
module memory_stage_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PC_W    = 32,
    parameter int MADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  rf_we_i,
    input  logic                  mem_we_i,
    input  logic                  mem_re_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic                  branch_i,
    input  logic                  check_eq_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [ADDR_W-1:0]     rf_waddr_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [PC_W-1:0]       pc_branch_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [MADDR_W-1:0]    dmem_addr_o,
    output logic [DATA_W/8-1:0]   dmem_be_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [PC_W-1:0]       pc_branch_o,
    output logic                  valid_o,
    output logic                  rf_we_o,
    output logic [ADDR_W-1:0]     rf_waddr_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  misalign_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t state;

    logic [OFF_W-1:0]  off;
    logic              mem_access;
    logic              raw_mis;
    logic              misaligned;
    int                nbytes;
    logic [2*NB-1:0]   be_mask;
    logic [2*NB-1:0]   be_wide;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;
    logic              fill;
    logic [DATA_W-1:0] load_data;
    logic              complete;

    assign off        = alu_result_i[OFF_W-1:0];
    assign mem_access = mem_we_i | mem_re_i;
    assign nbytes     = 1 << mem_size_i;

    always_comb begin
        raw_mis = 1'b0;
        case (mem_size_i)
            2'd0: raw_mis = 1'b0;
            2'd1: raw_mis = off[0];
            2'd2: raw_mis = |off[1:0];
            default: raw_mis = (NB < 8) || (|off);
        endcase
    end
    assign misaligned = mem_access & raw_mis;

    // Store lanes: enable mask shifted to the byte offset, data replicated per access size.
    always_comb begin
        be_mask      = '0;
        dmem_wdata_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) be_mask[i] = 1'b1;
            dmem_wdata_o[i*8 +: 8] = mem_wdata_i[(i & (nbytes - 1))*8 +: 8];
        end
    end
    assign be_wide     = be_mask << off;
    assign dmem_be_o   = be_wide[NB-1:0];
    assign dmem_addr_o = {alu_result_i[MADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem_we_o   = mem_we_i;

    // Load extract: align the addressed bytes to bit 0, then extend.
    assign shifted = dmem_rdata_i >> {off, 3'b000};
    always_comb begin
        sign_bit = 1'b0;
        case (mem_size_i)
            2'd0: sign_bit = shifted[7];
            2'd1: sign_bit = shifted[15];
            2'd2: sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
    end
    assign fill = sign_bit & ~mem_unsigned_i;

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NB; i++)
            load_data[i*8 +: 8] = (i < nbytes) ? shifted[i*8 +: 8] : {8{fill}};
    end

    always_comb begin
        dmem_req_o = 1'b0;
        complete   = 1'b1;
        if (valid_i && !reset) begin
            case (state)
                IDLE: begin
                    dmem_req_o = mem_access & ~misaligned;
                    complete   = ~mem_access | misaligned | (dmem_gnt_i & mem_we_i);
                end
                REQ: begin
                    dmem_req_o = 1'b1;
                    complete   = dmem_gnt_i & mem_we_i;
                end
                RSP:     complete = dmem_rvalid_i;
                default: complete = 1'b1;
            endcase
        end
    end

    assign stall_o     = valid_i & ~complete;
    assign pc_src_o    = valid_i & branch_i & (check_eq_i ^ (|alu_result_i));
    assign pc_branch_o = pc_branch_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            rf_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            rf_waddr_o <= '0;
            wb_data_o  <= '0;
        end else begin
            case (state)
                IDLE:
                    if (valid_i && mem_access && !misaligned)
                        state <= dmem_gnt_i ? (mem_re_i ? RSP : IDLE) : REQ;
                REQ:
                    if (dmem_gnt_i) state <= mem_re_i ? RSP : IDLE;
                RSP:
                    if (dmem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            valid_o    <= valid_i & complete;
            rf_we_o    <= valid_i & complete & rf_we_i & ~misaligned;
            misalign_o <= valid_i & complete & misaligned;
            if (valid_i && complete) begin
                rf_waddr_o <= rf_waddr_i;
                wb_data_o  <= (mem_re_i && !misaligned) ? load_data : alu_result_i;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu (DATA_W=32): ALU pass-through, stores, loads, misalignment, reset, branches.
module tb_memory_stage_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, rf_we_i, mem_we_i, mem_re_i, mem_unsigned_i, branch_i, check_eq_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_wdata_i, alu_result_i, pc_branch_i, dmem_rdata_i;
    logic [4:0]  rf_waddr_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, pc_branch_o, wb_data_o;
    logic [3:0]  dmem_be_o;
    logic        stall_o, pc_src_o, valid_o, rf_we_o, misalign_o;
    logic [4:0]  rf_waddr_o;

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage_lsu dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .rf_we_i(rf_we_i),
        .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .branch_i(branch_i), .check_eq_i(check_eq_i),
        .mem_wdata_i(mem_wdata_i), .rf_waddr_i(rf_waddr_i), .alu_result_i(alu_result_i),
        .pc_branch_i(pc_branch_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_branch_o(pc_branch_o),
        .valid_o(valid_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; rf_we_i = 0; mem_we_i = 0; mem_re_i = 0; mem_size_i = 2'd2;
        mem_unsigned_i = 0; branch_i = 0; check_eq_i = 0; mem_wdata_i = 0;
        rf_waddr_i = 0; alu_result_i = 0; pc_branch_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    endtask

    // Load granted at once, rvalid three cycles after the grant; checks the extended result.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
        valid_i = 1; mem_re_i = 1; rf_we_i = 1; rf_waddr_i = 5'd7;
        alu_result_i = addr; mem_size_i = size; mem_unsigned_i = uns; dmem_gnt_i = 1;
        #1 chk({tag, "_req"}, {31'b0, dmem_req_o}, 32'd1);
        chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        tick(); dmem_gnt_i = 0;
        #1 chk({tag, "_rsp_req"}, {31'b0, dmem_req_o}, 32'd0);
        chk({tag, "_rsp_stall"}, {31'b0, stall_o}, 32'd1);
        tick(); tick();
        dmem_rvalid_i = 1; dmem_rdata_i = rdata;
        #1 chk({tag, "_done_stall"}, {31'b0, stall_o}, 32'd0);
        tick(); clear_inputs();
        chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
        chk({tag, "_rfwe"}, {31'b0, rf_we_o}, 32'd1);
        chk({tag, "_data"}, wb_data_o, exp);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_rfwe", {31'b0, rf_we_o}, 32'd0);
        chk("rst_mis", {31'b0, misalign_o}, 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
        reset = 0;

        // ALU op passes straight through in one cycle.
        valid_i = 1; rf_we_i = 1; alu_result_i = 32'h1234; rf_waddr_i = 5'd5;
        #1 chk("alu_stall", {31'b0, stall_o}, 32'd0);
        chk("alu_req", {31'b0, dmem_req_o}, 32'd0);
        tick(); clear_inputs();
        chk("alu_valid", {31'b0, valid_o}, 32'd1);
        chk("alu_rfwe", {31'b0, rf_we_o}, 32'd1);
        chk("alu_data", wb_data_o, 32'h1234);
        chk("alu_waddr", {27'b0, rf_waddr_o}, 32'd5);

        // SB to 0x103 with the grant withheld for two cycles.
        valid_i = 1; mem_we_i = 1; mem_size_i = 2'd0; alu_result_i = 32'h103; mem_wdata_i = 32'h123456AB;
        #1 chk("sb_req0", {31'b0, dmem_req_o}, 32'd1);
        chk("sb_be", {28'b0, dmem_be_o}, 32'h8);
        chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
        chk("sb_addr", dmem_addr_o, 32'h100);
        chk("sb_we", {31'b0, dmem_we_o}, 32'd1);
        chk("sb_stall0", {31'b0, stall_o}, 32'd1);
        tick();
        chk("sb_req1", {31'b0, dmem_req_o}, 32'd1);
        chk("sb_stall1", {31'b0, stall_o}, 32'd1);
        chk("sb_bubble1", {31'b0, valid_o}, 32'd0);
        tick(); dmem_gnt_i = 1;
        #1 chk("sb_req2", {31'b0, dmem_req_o}, 32'd1);
        chk("sb_stall2", {31'b0, stall_o}, 32'd0);
        chk("sb_bubble2", {31'b0, valid_o}, 32'd0);
        tick(); clear_inputs();
        chk("sb_valid", {31'b0, valid_o}, 32'd1);
        chk("sb_rfwe", {31'b0, rf_we_o}, 32'd0);
        chk("sb_mis", {31'b0, misalign_o}, 32'd0);

        // SH to 0x102 granted immediately completes without stalling.
        valid_i = 1; mem_we_i = 1; mem_size_i = 2'd1; alu_result_i = 32'h102; mem_wdata_i = 32'hFFFF1234;
        dmem_gnt_i = 1;
        #1 chk("sh_be", {28'b0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'h12341234);
        chk("sh_stall", {31'b0, stall_o}, 32'd0);
        tick(); clear_inputs();
        chk("sh_valid", {31'b0, valid_o}, 32'd1);

        do_load("lb", 32'h101, 2'd0, 1'b0, 32'h00F08000, 32'hFFFFFF80);
        do_load("lbu", 32'h101, 2'd0, 1'b1, 32'h00F08000, 32'h00000080);
        do_load("lhu", 32'h102, 2'd1, 1'b1, 32'hBEEF0000, 32'h0000BEEF);
        do_load("lh", 32'h102, 2'd1, 1'b0, 32'hBEEF0000, 32'hFFFFBEEF);
        do_load("lw", 32'h104, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);

        // Misaligned LW: no request, completes at once, flagged.
        valid_i = 1; mem_re_i = 1; rf_we_i = 1; mem_size_i = 2'd2; alu_result_i = 32'h102;
        #1 chk("mis_req", {31'b0, dmem_req_o}, 32'd0);
        chk("mis_stall", {31'b0, stall_o}, 32'd0);
        tick(); clear_inputs();
        chk("mis_flag", {31'b0, misalign_o}, 32'd1);
        chk("mis_rfwe", {31'b0, rf_we_o}, 32'd0);
        chk("mis_valid", {31'b0, valid_o}, 32'd1);

        // Misaligned SH at 0x101.
        valid_i = 1; mem_we_i = 1; mem_size_i = 2'd1; alu_result_i = 32'h101;
        #1 chk("mis_sh_req", {31'b0, dmem_req_o}, 32'd0);
        tick(); clear_inputs();
        chk("mis_sh_flag", {31'b0, misalign_o}, 32'd1);

        // Reset while waiting for read data; the late rvalid must be ignored.
        valid_i = 1; mem_re_i = 1; rf_we_i = 1; mem_size_i = 2'd2; alu_result_i = 32'h200; dmem_gnt_i = 1;
        tick(); dmem_gnt_i = 0; reset = 1;
        tick(); clear_inputs(); reset = 0;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h55;
        #1 chk("rr_valid", {31'b0, valid_o}, 32'd0);
        chk("rr_rfwe", {31'b0, rf_we_o}, 32'd0);
        chk("rr_req", {31'b0, dmem_req_o}, 32'd0);
        tick(); dmem_rvalid_i = 0;
        chk("rr_late_valid", {31'b0, valid_o}, 32'd0);
        chk("rr_late_rfwe", {31'b0, rf_we_o}, 32'd0);
        // Back in IDLE: a new aligned load raises the request combinationally.
        valid_i = 1; mem_re_i = 1; mem_size_i = 2'd2; alu_result_i = 32'h300;
        #1 chk("rr_idle_req", {31'b0, dmem_req_o}, 32'd1);
        reset = 1;
        tick(); clear_inputs(); reset = 0;

        // Branch resolution.
        valid_i = 1; branch_i = 1; check_eq_i = 1; alu_result_i = 0; pc_branch_i = 32'h80000040;
        #1 chk("br_taken", {31'b0, pc_src_o}, 32'd1);
        chk("br_target", pc_branch_o, 32'h80000040);
        alu_result_i = 1;
        #1 chk("br_not_taken", {31'b0, pc_src_o}, 32'd0);
        check_eq_i = 0;
        #1 chk("bne_taken", {31'b0, pc_src_o}, 32'd1);
        valid_i = 0;
        #1 chk("br_invalid", {31'b0, pc_src_o}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
